// File: rtl/pdm_pkg.sv
// Shared types and arithmetic for the PDM modulator: loop order selector and
// the clamping adder used by the second-order integrators.
package pdm_pkg;

    typedef enum logic {
        PDM_ORDER1 = 1'b0,
        PDM_ORDER2 = 1'b1
    } mode_t;

    localparam int PDM_NBITS_DEFAULT = 16;
    // Headroom above the sample width for the second-order integrators.
    localparam int PDM_GUARD_BITS    = 3;

    // a + b + c clamped to the signed range of a w-bit word (w <= 62).
    function automatic logic signed [63:0] sat_add(
        input logic signed [63:0] a,
        input logic signed [63:0] b,
        input logic signed [63:0] c,
        input int                 w
    );
        logic signed [63:0] sum;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        sum = a + b + c;
        hi  = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo  = -hi - 64'sd1;
        if (sum > hi) begin
            return hi;
        end
        if (sum < lo) begin
            return lo;
        end
        return sum;
    endfunction

endpackage

// File: rtl/pdm_channel.sv
// One PDM modulator: first-order phase accumulator or second-order saturating
// double integrator, advanced on tick; clear zeroes all loop state.
module pdm_channel
    import pdm_pkg::*;
#(
    parameter int NBITS = PDM_NBITS_DEFAULT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             tick,
    input  logic             clear,
    input  logic             mode,
    input  logic [NBITS-1:0] din,
    output logic             dout
);

    localparam int W = NBITS + PDM_GUARD_BITS;
    localparam logic [W-1:0] HALF = W'(1) << (NBITS - 1);

    mode_t               order;
    logic [NBITS-1:0]    acc_q, acc_d;
    logic signed [W-1:0] i1_q, i1_d;
    logic signed [W-1:0] i2_q, i2_d;
    logic                dout_q, dout_d;

    logic [NBITS:0]      sum1;
    logic [W-1:0]        x;
    logic [W-1:0]        neg_y;
    logic signed [63:0]  i1_wide;
    logic signed [63:0]  i2_wide;
    logic                unused_hi;

    function automatic logic signed [63:0] widen(input logic [W-1:0] v);
        return {{(64 - W){v[W-1]}}, v};
    endfunction

    assign order = mode_t'(mode);

    always_comb begin
        acc_d  = acc_q;
        i1_d   = i1_q;
        i2_d   = i2_q;
        dout_d = dout_q;

        sum1  = {1'b0, acc_q} + {1'b0, din};
        x     = {{PDM_GUARD_BITS{1'b0}}, din} - HALF;
        // Feedback enters as -y: a high output pulls the loop down by half scale.
        neg_y = dout_q ? (~HALF + W'(1)) : HALF;

        i1_wide = sat_add(widen(i1_q), widen(x), widen(neg_y), W);
        i2_wide = sat_add(widen(i2_q), widen(i1_wide[W-1:0]), widen(neg_y), W);

        if (tick) begin
            if (clear) begin
                acc_d = '0;
                i1_d  = '0;
                i2_d  = '0;
            end else if (order == PDM_ORDER2) begin
                i1_d   = i1_wide[W-1:0];
                i2_d   = i2_wide[W-1:0];
                dout_d = ~i2_wide[W-1];
            end else begin
                acc_d  = sum1[NBITS-1:0];
                dout_d = sum1[NBITS];
            end
        end
    end

    // Saturation keeps the upper bits a pure sign extension.
    assign unused_hi = ^{i1_wide[63:W], i2_wide[63:W]};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc_q  <= '0;
            i1_q   <= '0;
            i2_q   <= '0;
            dout_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            i1_q   <= i1_d;
            i2_q   <= i2_d;
            dout_q <= dout_d;
        end
    end

    assign dout = dout_q;

endmodule

// File: rtl/pdm_sigma_delta.sv
// Multi-channel PDM output stage: prescaler, per-frame step counter, double-
// buffered sample frames with valid/ready intake and a sticky underrun flag.
module pdm_sigma_delta
    import pdm_pkg::*;
#(
    parameter int NBITS    = PDM_NBITS_DEFAULT,
    parameter int CHANNELS = 2,
    parameter int DIV      = 1,
    parameter int OSR      = 64
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [CHANNELS*NBITS-1:0] s_data,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic                      mode,
    input  logic                      underrun_clr,
    output logic                      underrun,
    output logic [CHANNELS-1:0]       dout
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SW = $clog2(OSR);

    logic [PW-1:0]             presc_q, presc_d;
    logic [SW-1:0]             step_q, step_d;
    logic [CHANNELS*NBITS-1:0] hold_q, hold_d;
    logic [CHANNELS*NBITS-1:0] active_q, active_d;
    logic                      hold_full_q, hold_full_d;
    logic                      underrun_q, underrun_d;
    mode_t                     mode_q, mode_d;

    logic tick;
    logic boundary;
    logic clear;

    assign tick     = (presc_q == PW'(DIV - 1));
    assign boundary = tick && (step_q == SW'(OSR - 1));
    assign clear    = boundary && (mode_t'(mode) != mode_q);
    assign s_ready  = ~hold_full_q;
    assign underrun = underrun_q;

    always_comb begin
        presc_d     = presc_q;
        step_d      = step_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        active_d    = active_q;
        underrun_d  = underrun_q;
        mode_d      = mode_q;

        if (tick) begin
            presc_d = '0;
            step_d  = (step_q == SW'(OSR - 1)) ? '0 : step_q + SW'(1);
        end else begin
            presc_d = presc_q + PW'(1);
        end

        if (underrun_clr) begin
            underrun_d = 1'b0;
        end

        // Boundary decisions use the holding register as it stood before this
        // edge; a same-cycle transfer only refills it for the next frame.
        if (boundary) begin
            mode_d = mode_t'(mode);
            if (hold_full_q) begin
                active_d    = hold_q;
                hold_full_d = 1'b0;
            end else begin
                underrun_d = 1'b1;
            end
        end

        if (s_valid && s_ready) begin
            hold_d      = s_data;
            hold_full_d = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            presc_q     <= '0;
            step_q      <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            active_q    <= '0;
            underrun_q  <= 1'b0;
            mode_q      <= PDM_ORDER1;
        end else begin
            presc_q     <= presc_d;
            step_q      <= step_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            active_q    <= active_d;
            underrun_q  <= underrun_d;
            mode_q      <= mode_d;
        end
    end

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
        pdm_channel #(
            .NBITS(NBITS)
        ) u_ch (
            .clock (clock),
            .reset (reset),
            .tick  (tick),
            .clear (clear),
            .mode  (mode_q),
            .din   (active_q[gi*NBITS +: NBITS]),
            .dout  (dout[gi])
        );
    end

endmodule

// File: tb/tb_pdm_sigma_delta.sv
// Self-checking bench for pdm_sigma_delta: one fast instance (DIV=1, OSR=64) for
// modulator behaviour and one slow instance (DIV=3, OSR=4) for the frame handshake.
module tb_pdm_sigma_delta;

    localparam longint HALF   = 32768;
    localparam longint SAT_HI = 262143;
    localparam longint SAT_LO = -262144;

    logic        clk     = 1'b0;
    logic        reset   = 1'b1;
    logic [31:0] a_data  = '0;
    logic [31:0] b_data  = '0;
    logic        a_valid = 1'b0;
    logic        b_valid = 1'b0;
    logic        a_mode  = 1'b0;
    logic        b_mode  = 1'b0;
    logic        a_clr   = 1'b0;
    logic        b_clr   = 1'b0;
    logic        a_ready, b_ready, a_under, b_under;
    logic [1:0]  a_dout, b_dout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pdm_sigma_delta #(.NBITS(16), .CHANNELS(2), .DIV(1), .OSR(64)) dut_a (
        .clock(clk), .reset(reset), .s_data(a_data), .s_valid(a_valid), .s_ready(a_ready),
        .mode(a_mode), .underrun_clr(a_clr), .underrun(a_under), .dout(a_dout)
    );

    pdm_sigma_delta #(.NBITS(16), .CHANNELS(2), .DIV(3), .OSR(4)) dut_b (
        .clock(clk), .reset(reset), .s_data(b_data), .s_valid(b_valid), .s_ready(b_ready),
        .mode(b_mode), .underrun_clr(b_clr), .underrun(b_under), .dout(b_dout)
    );

    // ---------------- reference model ----------------
    function automatic longint sat(input longint v);
        if (v > SAT_HI) return SAT_HI;
        if (v < SAT_LO) return SAT_LO;
        return v;
    endfunction

    // First order from a zero accumulator: ones after n steps = floor(n*d / 2^16).
    function automatic logic ord1_bit(input longint n, input longint d);
        return ((n * d) >>> 16) != (((n - 1) * d) >>> 16);
    endfunction

    function automatic void ord2_step(input longint d, inout longint i1, inout longint i2,
                                      inout logic out);
        longint x;
        longint y;
        x   = d - HALF;
        y   = out ? HALF : -HALF;
        i1  = sat(i1 + x - y);
        i2  = sat(i2 + i1 - y);
        out = (i2 >= 0);
    endfunction

    // ---------------- helpers ----------------
    // Release lands on a falling edge, so the next rising edge is cycle 1.
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic step_to(inout int k, input int target);
        while (k < target) begin
            @(negedge clk);
            k++;
        end
    endtask

    // Runs 64 warm-up ticks (frame 0 active) then 1024 ticks on the new frame.
    task automatic run_stream(input string name, input logic m, input logic [15:0] d0,
                              input logic [15:0] d1, output int ones0, output int ones1);
        longint      i1[2];
        longint      i2[2];
        longint      obs;
        logic        out[2];
        longint      d[2];
        logic        exp_b;
        int          bit_err;
        int          pre_ones;
        int          sat_hits;
        d[0] = longint'(d0);
        d[1] = longint'(d1);
        for (int c = 0; c < 2; c++) begin
            i1[c]  = 0;
            i2[c]  = 0;
            out[c] = 1'b0;
        end
        ones0 = 0; ones1 = 0; bit_err = 0; pre_ones = 0; sat_hits = 0;
        a_mode = m; a_data = {d1, d0}; a_valid = 1'b1; a_clr = 1'b0;
        do_reset();
        repeat (64) begin
            @(negedge clk);
            if (a_dout != 2'b00) pre_ones++;
        end
        for (int n = 1; n <= 1024; n++) begin
            @(negedge clk);
            for (int c = 0; c < 2; c++) begin
                if (m) begin
                    ord2_step(d[c], i1[c], i2[c], out[c]);
                    exp_b = out[c];
                end else begin
                    exp_b = ord1_bit(longint'(n), d[c]);
                end
                if (a_dout[c] !== exp_b) bit_err++;
            end
            ones0 += int'(a_dout[0]);
            ones1 += int'(a_dout[1]);
            obs = dut_a.g_ch[0].u_ch.i1_q; if (obs >= SAT_HI || obs <= SAT_LO) sat_hits++;
            obs = dut_a.g_ch[0].u_ch.i2_q; if (obs >= SAT_HI || obs <= SAT_LO) sat_hits++;
            obs = dut_a.g_ch[1].u_ch.i1_q; if (obs >= SAT_HI || obs <= SAT_LO) sat_hits++;
            obs = dut_a.g_ch[1].u_ch.i2_q; if (obs >= SAT_HI || obs <= SAT_LO) sat_hits++;
        end
        checks++;
        if (pre_ones !== 0) begin
            errors++;
            $display("FAIL %s warmup: ones %0d required 0", name, pre_ones);
        end
        checks++;
        if (bit_err !== 0) begin
            errors++;
            $display("FAIL %s stream: bit mismatches %0d required 0", name, bit_err);
        end
        checks++;
        if (a_under !== 1'b0) begin
            errors++;
            $display("FAIL %s underrun: got %b required 0", name, a_under);
        end
        if (m) begin
            checks++;
            if (sat_hits !== 0) begin
                errors++;
                $display("FAIL %s no_sat: limit hits %0d required 0", name, sat_hits);
            end
        end
        $display("stream %s mode %0d din0 %h din1 %h ones0 %0d ones1 %0d", name, m, d0, d1,
                 ones0, ones1);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        int k = 0;
        b_valid = 1'b1; b_data = 32'hFFFF_FFFF; b_mode = 1'b0; b_clr = 1'b0;
        do_reset();
        step_to(k, 1);
        b_valid = 1'b0;
        step_to(k, 24);
        checks++;
        if (b_under !== 1'b1) begin
            errors++;
            $display("FAIL reset_pre_underrun: got %b required 1", b_under);
        end
        b_valid = 1'b1;
        step_to(k, 25);
        b_valid = 1'b0;
        checks++;
        if (b_dout !== 2'b11 || b_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_pre_state: dout %b ready %b required 11 0", b_dout, b_ready);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (b_dout !== 2'b00 || b_ready !== 1'b1 || b_under !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: dout %b ready %b underrun %b required 00 1 0",
                     b_dout, b_ready, b_under);
        end
        @(negedge clk);
        reset = 1'b0;
        k = 0;
        step_to(k, 12);
        checks++;
        if (b_under !== 1'b1 || dut_b.active_q !== 32'h0 || b_dout !== 2'b00) begin
            errors++;
            $display("FAIL reset_discard: underrun %b active %h dout %b required 1 00000000 00",
                     b_under, dut_b.active_q, b_dout);
        end
        $display("reset mid-stream done");
    endtask

    task automatic test_order1();
        int o0, o1;
        logic [15:0] r;
        run_stream("o1_4000", 1'b0, 16'h4000, 16'h4000, o0, o1);
        checks++;
        if (o0 !== 256) begin
            errors++;
            $display("FAIL o1_4000_count: ones %0d required 256", o0);
        end
        run_stream("o1_0000", 1'b0, 16'h0000, 16'h0000, o0, o1);
        checks++;
        if (o0 !== 0) begin
            errors++;
            $display("FAIL o1_0000_count: ones %0d required 0", o0);
        end
        run_stream("o1_ffff", 1'b0, 16'hFFFF, 16'hFFFF, o0, o1);
        checks++;
        if (o0 < 1023) begin
            errors++;
            $display("FAIL o1_ffff_count: ones %0d required >=1023", o0);
        end
        r = 16'($urandom);
        run_stream("o1_rand", 1'b0, r, ~r, o0, o1);
    endtask

    task automatic test_order2();
        int o0, o1;
        logic [15:0] r0, r1;
        run_stream("o2_8000", 1'b1, 16'h8000, 16'h8000, o0, o1);
        checks++;
        if (o0 < 510 || o0 > 514) begin
            errors++;
            $display("FAIL o2_8000_count: ones %0d required 512+/-2", o0);
        end
        run_stream("o2_c000", 1'b1, 16'hC000, 16'hC000, o0, o1);
        checks++;
        if (o0 < 764 || o0 > 772) begin
            errors++;
            $display("FAIL o2_c000_count: ones %0d required 768+/-4", o0);
        end
        for (int t = 0; t < 2; t++) begin
            r0 = 16'($urandom_range(16'hF000, 16'h1000));
            r1 = 16'($urandom_range(16'hF000, 16'h1000));
            run_stream("o2_rand", 1'b1, r0, r1, o0, o1);
        end
    endtask

    task automatic test_channels();
        int o0, o1;
        run_stream("chan", 1'b0, 16'h4000, 16'hC000, o0, o1);
        checks++;
        if (o0 !== 256 || o1 !== 768) begin
            errors++;
            $display("FAIL chan_counts: ones %0d %0d required 256 768", o0, o1);
        end
    endtask

    task automatic test_handshake();
        int bad = 0;
        b_valid = 1'b1; b_data = $urandom; b_clr = 1'b0; b_mode = 1'b0;
        do_reset();
        for (int k = 1; k <= 48; k++) begin
            @(negedge clk);
            if (b_ready !== logic'((k % 12) == 0)) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL handshake_ready: bad cycles %0d required 0", bad);
        end
        $display("handshake s_ready pattern over 48 cycles, bad %0d", bad);
    endtask

    task automatic test_underrun();
        int k = 0;
        logic [31:0] f1;
        f1 = $urandom;
        b_valid = 1'b1; b_data = f1; b_clr = 1'b0;
        do_reset();
        step_to(k, 1);
        b_valid = 1'b0;
        step_to(k, 23);
        checks++;
        if (b_under !== 1'b0) begin
            errors++;
            $display("FAIL underrun_early: got %b required 0", b_under);
        end
        step_to(k, 24);
        checks++;
        if (b_under !== 1'b1 || dut_b.active_q !== f1) begin
            errors++;
            $display("FAIL underrun_set: underrun %b active %h required 1 %h",
                     b_under, dut_b.active_q, f1);
        end
        step_to(k, 26);
        b_clr = 1'b1;
        step_to(k, 27);
        b_clr = 1'b0;
        checks++;
        if (b_under !== 1'b0) begin
            errors++;
            $display("FAIL underrun_clr: got %b required 0", b_under);
        end
        step_to(k, 35);
        checks++;
        if (b_under !== 1'b0) begin
            errors++;
            $display("FAIL underrun_hold_clear: got %b required 0", b_under);
        end
        b_clr = 1'b1;
        step_to(k, 36);
        b_clr = 1'b0;
        checks++;
        if (b_under !== 1'b1) begin
            errors++;
            $display("FAIL underrun_set_wins: got %b required 1", b_under);
        end
        $display("underrun sequence frame %h done", f1);
    endtask

    task automatic test_back_to_back();
        int k = 0;
        logic [31:0] f2;
        f2 = $urandom | 32'h1;
        b_valid = 1'b0; b_clr = 1'b0;
        do_reset();
        step_to(k, 13);
        b_clr = 1'b1;
        step_to(k, 14);
        b_clr = 1'b0;
        step_to(k, 23);
        b_valid = 1'b1; b_data = f2;
        step_to(k, 24);
        b_valid = 1'b0;
        checks++;
        if (b_under !== 1'b1 || dut_b.active_q !== 32'h0 || b_ready !== 1'b0) begin
            errors++;
            $display("FAIL boundary_xfer: underrun %b active %h ready %b required 1 00000000 0",
                     b_under, dut_b.active_q, b_ready);
        end
        step_to(k, 25);
        b_clr = 1'b1;
        step_to(k, 26);
        b_clr = 1'b0;
        step_to(k, 36);
        checks++;
        if (b_under !== 1'b0 || dut_b.active_q !== f2 || b_ready !== 1'b1) begin
            errors++;
            $display("FAIL boundary_next: underrun %b active %h ready %b required 0 %h 1",
                     b_under, dut_b.active_q, b_ready, f2);
        end
        $display("boundary transfer frame %h done", f2);
    endtask

    task automatic test_mode_switch();
        int k = 0;
        longint i1 = 0, i2 = 0, obs1, obs2;
        logic out = 1'b0;
        logic [15:0] d;
        d = 16'($urandom_range(16'hE000, 16'h2000));
        a_mode = 1'b1; a_data = {d, d}; a_valid = 1'b1; a_clr = 1'b0;
        do_reset();
        step_to(k, 64);
        while (k < 127) begin
            @(negedge clk);
            k++;
            ord2_step(longint'(d), i1, i2, out);
            if (k == 100) a_mode = 1'b0;
        end
        obs1 = dut_a.g_ch[0].u_ch.i1_q;
        obs2 = dut_a.g_ch[0].u_ch.i2_q;
        checks++;
        if (obs1 !== i1 || obs2 !== i2 || a_dout[0] !== out) begin
            errors++;
            $display("FAIL mode_pre_boundary: i1 %0d i2 %0d dout %b required %0d %0d %b",
                     obs1, obs2, a_dout[0], i1, i2, out);
        end
        step_to(k, 128);
        obs1 = dut_a.g_ch[0].u_ch.i1_q;
        obs2 = dut_a.g_ch[0].u_ch.i2_q;
        checks++;
        if (obs1 !== 0 || obs2 !== 0 || dut_a.g_ch[0].u_ch.acc_q !== 16'h0) begin
            errors++;
            $display("FAIL mode_clear: i1 %0d i2 %0d acc %h required 0 0 0000",
                     obs1, obs2, dut_a.g_ch[0].u_ch.acc_q);
        end
        step_to(k, 129);
        checks++;
        if (dut_a.g_ch[0].u_ch.acc_q !== d || a_dout[0] !== 1'b0) begin
            errors++;
            $display("FAIL mode_new_order: acc %h dout %b required %h 0",
                     dut_a.g_ch[0].u_ch.acc_q, a_dout[0], d);
        end
        $display("mode switch din %h done", d);
    endtask

    initial begin
        test_reset();
        test_order1();
        test_order2();
        test_channels();
        test_handshake();
        test_underrun();
        test_back_to_back();
        test_mode_switch();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
